// File: rtl/loop_sequencer_8.sv
// Loop control FSM: clears/increments an external 3-bit index counter and sequences
// read, step launch, completion wait and write-back per index. Optional abort input: LOOP_SEQ_ABORT_EN.
module loop_sequencer_8 #(
  parameter int unsigned LAST_IDX = 7,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] cnt_val,
  input  logic       step_ready,
`ifdef LOOP_SEQ_ABORT_EN
  input  logic       abort,
`endif
  output logic       cnt_clr,
  output logic       cnt_inc,
  output logic       rd_en,
  output logic       step_go,
  output logic       wr_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RD, S_GO, S_WAIT, S_WR, S_DONE, S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WD_W-1:0] r_wd;
  logic            r_err;
  logic            w_last;
  logic            w_abort;

  assign w_last = (cnt_val == 3'(LAST_IDX));

`ifdef LOOP_SEQ_ABORT_EN
  // DONE counts as busy but is not abortable: the pass has already completed.
  assign w_abort = abort && (r_state inside {S_CLR, S_RD, S_GO, S_WAIT, S_WR});
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_GO)
        r_wd <= WD_W'(TIMEOUT - 1);
      else if (r_state == S_WAIT && !step_ready && r_wd != '0)
        r_wd <= r_wd - WD_W'(1);

      if (r_state == S_WAIT && w_next == S_ERR)
        r_err <= 1'b1;
      else if (r_state == S_ERR && start)
        r_err <= 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_CLR;
      S_CLR:  w_next = S_RD;
      S_RD:   w_next = S_GO;
      S_GO:   w_next = S_WAIT;
      S_WAIT: begin
        if (step_ready)      w_next = S_WR;
        else if (r_wd == '0) w_next = S_ERR;
      end
      S_WR:   w_next = w_last ? S_DONE : S_RD;
      S_DONE: w_next = S_IDLE;
      S_ERR:  if (start) w_next = S_CLR;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    rd_en   = 1'b0;
    step_go = 1'b0;
    wr_en   = 1'b0;
    done    = 1'b0;
    busy    = (r_state != S_IDLE) && (r_state != S_ERR);
    err     = r_err;
    unique case (r_state)
      S_CLR:  cnt_clr = 1'b1;
      S_RD:   rd_en   = 1'b1;
      S_GO:   step_go = 1'b1;
      S_WR: begin
        wr_en   = 1'b1;
        cnt_inc = !w_last;
      end
      S_DONE: done    = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_loop_sequencer_8.sv
// Scoreboard bench for loop_sequencer_8: expected strobe events queued by stimulus, popped by monitor.
module tb_loop_sequencer_8;

  localparam int unsigned TIMEOUT = 15;

  localparam logic [6:0] E_CLR  = 7'b1000000;
  localparam logic [6:0] E_INC  = 7'b0100000;
  localparam logic [6:0] E_RD   = 7'b0010000;
  localparam logic [6:0] E_GO   = 7'b0001000;
  localparam logic [6:0] E_WR   = 7'b0000100;
  localparam logic [6:0] E_DONE = 7'b0000010;
  localparam logic [6:0] E_ERR  = 7'b0000001;

  typedef struct {
    logic [6:0]  outs;
    logic [2:0]  idx;
    bit          idx_chk;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, step_ready;
  logic [2:0] cnt_val;
  logic cnt_clr, cnt_inc, rd_en, step_go, wr_en, busy, done, err;
`ifdef LOOP_SEQ_ABORT_EN
  logic abort;
`endif

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  int unsigned s0;
  int unsigned dly[8];
  int unsigned rmode = 0;
  int unsigned rcnt = 0;
  logic [2:0]  r_cnt = '0;
  logic [6:0]  mon_w;
  exp_t        mon_e;
  logic        err_q = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index counter model the sequencer drives.
  always @(posedge clk) begin
    if (reset || cnt_clr) r_cnt <= '0;
    else if (cnt_inc)     r_cnt <= r_cnt + 3'd1;
  end
  assign cnt_val = r_cnt;

  loop_sequencer_8 #(.LAST_IDX(7), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .cnt_val(cnt_val), .step_ready(step_ready),
`ifdef LOOP_SEQ_ABORT_EN
    .abort(abort),
`endif
    .cnt_clr(cnt_clr), .cnt_inc(cnt_inc), .rd_en(rd_en), .step_go(step_go),
    .wr_en(wr_en), .busy(busy), .done(done), .err(err)
  );

  // Datapath responder: 0 = ready tied high, 1 = ready after dly[idx] extra WAIT cycles, 2 = never.
  always @(negedge clk) begin
    if (reset) begin
      rcnt = 0;
      step_ready = 1'b0;
    end else if (rmode == 0) step_ready = 1'b1;
    else if (rmode == 2)     step_ready = 1'b0;
    else if (step_go) begin
      rcnt = dly[cnt_val] + 1;
      step_ready = 1'b0;
    end else if (rcnt > 0) begin
      rcnt = rcnt - 1;
      step_ready = (rcnt == 0);
    end else step_ready = 1'b0;
  end

  always @(negedge clk) begin
    mon_w = {cnt_clr, cnt_inc, rd_en, step_go, wr_en, done, err & ~err_q};
    err_q = err;
    if (mon_w != '0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_event: got outs=%b idx=%0d at cyc=%0d, required no event", mon_w, cnt_val, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (mon_w !== mon_e.outs || cyc != mon_e.cyc || (mon_e.idx_chk && cnt_val !== mon_e.idx)) begin
          n_errors++;
          $display("FAIL event: got outs=%b idx=%0d cyc=%0d, required outs=%b idx=%0d cyc=%0d",
                   mon_w, cnt_val, cyc, mon_e.outs, mon_e.idx, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input string name);
    chk(name, {24'd0, cnt_clr, cnt_inc, rd_en, step_go, wr_en, done, err, busy}, 32'd0);
  endtask

  task automatic chk_empty(input string name);
    chk(name, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push(input logic [6:0] o, input logic [2:0] i, input bit ic, input int unsigned c);
    exp_t e;
    e.outs = o; e.idx = i; e.idx_chk = ic; e.cyc = c;
    sb.push_back(e);
  endtask

  // Expected events for a pass started at cycle s; stop<8 ends after GO of that index.
  task automatic gen_pass(input int unsigned s, input int unsigned stop, input bit add_err);
    int unsigned c;
    c = s + 1;
    push(E_CLR, 3'd0, 1'b0, c);
    for (int unsigned i = 0; i < 8; i++) begin
      c++; push(E_RD, 3'(i), 1'b1, c);
      c++; push(E_GO, 3'(i), 1'b1, c);
      if (i == stop) break;
      c += dly[i] + 1;
      c++; push((i != 7) ? (E_WR | E_INC) : E_WR, 3'(i), 1'b1, c);
    end
    if (stop >= 8) push(E_DONE, 3'd7, 1'b1, c + 1);
    if (add_err) push(E_ERR, 3'd0, 1'b1, c + TIMEOUT + 1);
  endtask

  task automatic begin_pass(input int unsigned stop, input bit add_err);
    s0 = cyc + 1;
    wait_until(s0);
    gen_pass(s0, stop, add_err);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_start_at(input int unsigned c);
    wait_until(c);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0;
`ifdef LOOP_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    foreach (dly[i]) dly[i] = 0;
    repeat (3) @(negedge clk);
    chk_idle("reset_state");
    reset = 1'b0;
    @(negedge clk);

    // Full pass, ready tied high: done at s+34, busy across the pass.
    rmode = 0;
    begin_pass(8, 1'b0);
    for (int unsigned k = 1; k <= 35; k++) begin
      wait_until(s0 + k);
      chk("busy_window", {31'd0, busy}, {31'd0, (k <= 34) ? 1'b1 : 1'b0});
    end
    wait_until(s0 + 37);
    chk_empty("pass_immediate_drain");

    // Three extra WAIT cycles at index 4.
    rmode = 1;
    dly[4] = 3;
    begin_pass(8, 1'b0);
    wait_until(s0 + 40);
    chk("delay_no_err", {31'd0, err}, 32'd0);
    chk_empty("pass_delay_drain");
    dly[4] = 0;

    // No step_ready: ERR after TIMEOUT WAIT cycles, then restart clears err.
    rmode = 2;
    begin_pass(0, 1'b1);
    wait_until(s0 + 20);
    chk("timeout_err", {31'd0, err}, 32'd1);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    wait_until(s0 + 25);
    chk("timeout_err_sticky", {31'd0, err}, 32'd1);
    chk_empty("timeout_drain");
    rmode = 0;
    begin_pass(8, 1'b0);
    chk("restart_err_clear", {31'd0, err}, 32'd0);
    wait_until(s0 + 37);
    chk_empty("restart_drain");

    // start pulses while busy must not disturb the pass.
    begin_pass(8, 1'b0);
    pulse_start_at(s0 + 5);
    pulse_start_at(s0 + 20);
    pulse_start_at(s0 + 33);
    wait_until(s0 + 35);
    chk("start_ignored_idle", {31'd0, busy}, 32'd0);
    wait_until(s0 + 37);
    chk_empty("start_ignored_drain");

    // Reset during WAIT at index 3, then a clean pass from index 0.
    rmode = 1;
    dly[3] = 10;
    begin_pass(3, 1'b0);
    wait_until(s0 + 16);
    reset = 1'b1;
    wait_until(s0 + 17);
    chk_idle("reset_mid_pass");
    chk_empty("reset_mid_drain");
    reset = 1'b0;
    dly[3] = 0;
    rmode = 0;
    begin_pass(8, 1'b0);
    wait_until(s0 + 37);
    chk_empty("post_reset_drain");

`ifdef LOOP_SEQ_ABORT_EN
    rmode = 1;
    begin_pass(2, 1'b0);
    wait_until(s0 + 11);
    abort = 1'b1;
    wait_until(s0 + 12);
    abort = 1'b0;
    chk_idle("abort_in_go");
    begin_pass(1, 1'b0);
    wait_until(s0 + 8);
    abort = 1'b1;
    wait_until(s0 + 9);
    abort = 1'b0;
    chk_idle("abort_vs_ready");
    wait_until(s0 + 12);
    chk_empty("abort_drain");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
